// File: rtl/bcd_display_scan_if.sv
// Digit/mask inputs and multiplexed 7-segment outputs of the display scanner.
interface bcd_display_scan_if;
  logic [3:0] ms_hr, ls_hr, ms_min, ls_min, ms_sec, ls_sec;
  logic [5:0] blink_mask, dp_mask;
  logic       blank_lz;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  modport master (
    output ms_hr, ls_hr, ms_min, ls_min, ms_sec, ls_sec,
    output blink_mask, dp_mask, blank_lz,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  ms_hr, ls_hr, ms_min, ls_min, ms_sec, ls_sec,
    input  blink_mask, dp_mask, blank_lz,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/bcd_display_scan.sv
// Six-digit common-anode 7-segment scanner for HH:MM:SS with a per-frame
// snapshot, blinking, decimal points and hour-tens leading-zero blanking.
module bcd_display_scan #(
  parameter int CLK_DIV      = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input logic          clk,
  input logic          rst,
  bcd_display_scan_if.slave bus
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  logic [PW-1:0] presc_p0;
  logic [2:0]    idx_p0;
  logic [23:0]   digits_p0;
  logic [5:0]    blink_p0, dpm_p0;
  logic          blz_p0;
  logic [FW-1:0] fcnt_p0;
  logic          phase_p0;
  logic          wrap_p1;
  logic          tick, last;

  assign tick = (presc_p0 == PW'(CLK_DIV - 1));
  assign last = tick && (idx_p0 == 3'd5);

  // Stage p0: prescaler, digit index, frame snapshot and blink phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_p0  <= '0;
      idx_p0    <= '0;
      digits_p0 <= '0;
      blink_p0  <= '0;
      dpm_p0    <= '0;
      blz_p0    <= 1'b0;
      fcnt_p0   <= '0;
      phase_p0  <= 1'b0;
      wrap_p1   <= 1'b0;
    end else begin
      presc_p0 <= tick ? '0 : presc_p0 + 1'b1;
      if (tick)
        idx_p0 <= (idx_p0 == 3'd5) ? 3'd0 : idx_p0 + 3'd1;
      // Phase flips on the same edge the snapshot loads so a frame never mixes phases.
      if (last) begin
        digits_p0 <= {bus.ms_hr, bus.ls_hr, bus.ms_min, bus.ls_min, bus.ms_sec, bus.ls_sec};
        blink_p0  <= bus.blink_mask;
        dpm_p0    <= bus.dp_mask;
        blz_p0    <= bus.blank_lz;
        if (fcnt_p0 == FW'(BLINK_FRAMES - 1)) begin
          fcnt_p0  <= '0;
          phase_p0 <= ~phase_p0;
        end else begin
          fcnt_p0 <= fcnt_p0 + 1'b1;
        end
      end
      wrap_p1 <= last;
    end
  end

  logic [3:0] digit;
  logic       blank;
  logic [5:0] an_nxt;
  logic [6:0] seg_nxt;
  logic       dp_nxt;

  always_comb begin
    digit   = digits_p0[3:0];
    blank   = 1'b0;
    an_nxt  = 6'b111111;
    seg_nxt = 7'b1111111;
    dp_nxt  = 1'b1;
    case (idx_p0)
      3'd1:    digit = digits_p0[7:4];
      3'd2:    digit = digits_p0[11:8];
      3'd3:    digit = digits_p0[15:12];
      3'd4:    digit = digits_p0[19:16];
      3'd5:    digit = digits_p0[23:20];
      default: digit = digits_p0[3:0];
    endcase
    blank = (phase_p0 && blink_p0[idx_p0]) ||
            ((idx_p0 == 3'd5) && blz_p0 && (digit == 4'd0));
    if (!blank) begin
      an_nxt  = ~(6'b000001 << idx_p0);
      seg_nxt = seg_decode(digit);
      dp_nxt  = ~dpm_p0[idx_p0];
    end
  end

  // Stage p1: registered display drive, frame_done aligned with the new frame's first digit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.an         <= 6'b111111;
      bus.seg        <= 7'b1111111;
      bus.dp         <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      bus.an         <= an_nxt;
      bus.seg        <= seg_nxt;
      bus.dp         <= dp_nxt;
      bus.frame_done <= wrap_p1;
    end
  end
endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan: directed scenarios plus random traffic against a
// frame-arithmetic model of what the display must show after each clock edge.
module tb_bcd_display_scan;
  localparam int CD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = 6 * CD;
  localparam int NF    = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bcd_display_scan_if bus();

  bcd_display_scan #(.CLK_DIV(CD), .BLINK_FRAMES(BF)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int k = 0;                     // clock edges since reset release
  logic [36:0] snap [NF];        // {blz, dp_mask, blink_mask, 6 BCD digits} per frame
  logic [6:0]  dec [16];

  initial begin
    dec[0] = 7'b1000000; dec[1] = 7'b1111001; dec[2] = 7'b0100100; dec[3] = 7'b0110000;
    dec[4] = 7'b0011001; dec[5] = 7'b0010010; dec[6] = 7'b0000010; dec[7] = 7'b1111000;
    dec[8] = 7'b0000000; dec[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) dec[i] = 7'b0111111;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at k=%0d t=%0t: got %h expected %h", name, k, $time, act, exp);
  endtask

  function automatic logic [36:0] cur_inputs();
    return {bus.blank_lz, bus.dp_mask, bus.blink_mask,
            bus.ms_hr, bus.ls_hr, bus.ms_min, bus.ls_min, bus.ms_sec, bus.ls_sec};
  endfunction

  // Frame f displays what the inputs held at the last edge of frame f-1; frame 0 sees zeros.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k <= 0;
      for (int i = 0; i < NF; i++) snap[i] <= '0;
    end else begin
      k <= k + 1;
      if (((k + 1) % FRAME == 0) && ((k + 1) / FRAME < NF))
        snap[(k + 1) / FRAME] <= cur_inputs();
    end
  end

  function automatic logic [14:0] model(input int kk);
    int p, idx, f, d;
    logic [36:0] s;
    logic ph, blank, fd;
    if (rst || kk == 0) return {6'b111111, 7'b1111111, 1'b1, 1'b0};
    p   = kk - 1;
    idx = (p / CD) % 6;
    f   = p / FRAME;
    s   = snap[(f < NF) ? f : NF - 1];
    d   = int'(s[4*idx +: 4]);
    ph  = ((f / BF) % 2) == 1;
    blank = (ph && s[24 + idx]) || (idx == 5 && s[36] && d == 0);
    fd  = (p % FRAME == 0) && (f >= 1);
    if (blank) return {6'b111111, 7'b1111111, 1'b1, fd};
    return {~(6'b000001 << idx), dec[d], ~s[30 + idx], fd};
  endfunction

  always @(negedge clk)
    chk("scan", {17'd0, bus.an, bus.seg, bus.dp, bus.frame_done}, {17'd0, model(k)});

  task automatic wait_k(input int t);
    int n;
    n = 0;
    while (k < t && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (k != t) chk("wait_k", k, t);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ms_hr = 4'd2; bus.ls_hr = 4'd3; bus.ms_min = 4'd5; bus.ls_min = 4'd9;
    bus.ms_sec = 4'd5; bus.ls_sec = 4'd8;
    bus.blink_mask = 6'b0; bus.dp_mask = 6'b0; bus.blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_an", bus.an, 6'b111111);
    chk("reset_seg", bus.seg, 7'b1111111);
    #2 rst = 1'b0;

    // Zero snapshot first, then 23:59:58
    wait_k(1);  chk("f0_an0", bus.an, 6'b111110); chk("f0_seg0", bus.seg, 7'b1000000);
    wait_k(24); chk("f0_fd_low", bus.frame_done, 1'b0);
    wait_k(25); chk("f1_fd", bus.frame_done, 1'b1); chk("f1_seg0", bus.seg, 7'b0000000);
    wait_k(26); chk("f1_fd_pulse", bus.frame_done, 1'b0);
    wait_k(33); bus.ls_sec = 4'd9;
    wait_k(45); chk("f1_an5", bus.an, 6'b011111); chk("f1_seg5", bus.seg, 7'b0100100);
    wait_k(49); chk("f2_seg0_9", bus.seg, 7'b0010000);
    bus.ms_hr = 4'd0; bus.blank_lz = 1'b1;

    // Leading-zero blanking on and then off
    wait_k(93); chk("lz_an", bus.an, 6'b111111); chk("lz_seg", bus.seg, 7'b1111111);
    wait_k(94); bus.blank_lz = 1'b0;
    wait_k(117); chk("nolz_an", bus.an, 6'b011111); chk("nolz_seg", bus.seg, 7'b1000000);
    wait_k(118); bus.dp_mask = 6'b010100; bus.ls_hr = 4'd12;

    // Decimal points and invalid-BCD dash
    wait_k(129); chk("dp2_an", bus.an, 6'b111011); chk("dp2", bus.dp, 1'b0);
    wait_k(133); chk("dp3", bus.dp, 1'b1);
    wait_k(137); chk("dash_seg", bus.seg, 7'b0111111); chk("dp4", bus.dp, 1'b0);
    wait_k(138); bus.blink_mask = 6'b000011;

    // Blink: frames 6,7 blanked (phase 1), frames 8,9 visible
    wait_k(145); chk("blink_an0", bus.an, 6'b111111); chk("blink_seg0", bus.seg, 7'b1111111);
    wait_k(153); chk("blink_an2", bus.an, 6'b111011);
    wait_k(193); chk("unblink_an0", bus.an, 6'b111110); chk("unblink_seg0", bus.seg, 7'b0010000);

    // Asynchronous reset in the middle of idx 3
    wait_k(230);
    #2 rst = 1'b1;
    #1;
    chk("async_an", bus.an, 6'b111111); chk("async_seg", bus.seg, 7'b1111111);
    chk("async_dp", bus.dp, 1'b1); chk("async_fd", bus.frame_done, 1'b0);
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b0;
    wait_k(1); chk("rr_an0", bus.an, 6'b111110); chk("rr_seg0", bus.seg, 7'b1000000);
    wait_k(4); chk("rr_an0_end", bus.an, 6'b111110);
    wait_k(5); chk("rr_an1", bus.an, 6'b111101);
    wait_k(25); chk("rr_fd", bus.frame_done, 1'b1);

    // Random traffic, including invalid BCD and occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      case ($urandom_range(0, 11))
        0: bus.ls_sec     = 4'($urandom_range(0, 15));
        1: bus.ms_sec     = 4'($urandom_range(0, 15));
        2: bus.ls_min     = 4'($urandom_range(0, 15));
        3: bus.ms_min     = 4'($urandom_range(0, 15));
        4: bus.ls_hr      = 4'($urandom_range(0, 15));
        5: bus.ms_hr      = 4'($urandom_range(0, 2));
        6: bus.blink_mask = 6'($urandom_range(0, 63));
        7: bus.dp_mask    = 6'($urandom_range(0, 63));
        8: bus.blank_lz   = 1'($urandom_range(0, 1));
        default: ;
      endcase
      if ($urandom_range(0, 799) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
